// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control unit for the multicycle RV32I teaching core. One instruction is
//   sequenced at a time through FETCH, DECODE, EXEC, MEM and WB. The
//   controller drives the shared datapath: PC, IR, operand mux, ALU op,
//   register file and the single unified memory port.
//
//   Handshake: a memory access is in flight while mem_req=1. The access
//   completes in the cycle where mem_req=1 and mem_ready=1. mem_ready is
//   ignored whenever mem_req=0. mem_we is meaningful only while mem_req=1.
//
//   Parameter:
//     WAIT_LIMIT   max cycles mem_req may stay high without mem_ready
//                  (0 disables the watchdog, legal range 0..65535)
//   Build option:
//     ILLEGAL_TRAP_EN  when defined, an unsupported opcode halts the
//                      controller; otherwise it retires as a NOP.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     opcode[6:0]        IR[6:0], valid from DECODE onward
//     alu_zero           ALU zero flag (used by beq in EXEC)
//     mem_ready          memory completes the current access
//     mem_req, mem_we    memory request / write strobe
//     mem_addr_src       0 = PC, 1 = ALU result register
//     ir_write           load IR from memory read data
//     pc_write, pc_src   PC update enable, 0 = PC+4, 1 = PC+imm
//     alu_src_b          0 = rs2, 1 = immediate
//     alu_op[1:0]        00 add, 01 sub, 10 decode funct3/funct7
//     reg_write, wb_sel  register write enable, 0 = ALU, 1 = memory data
//     retired            one-cycle pulse when an instruction completes
//     halted             controller stopped in HALT
//     mem_timeout        sticky watchdog flag
//     state[2:0]         current state (debug)
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       retired,
  output logic       halted,
  output logic       mem_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  state_t      cur;
  state_t      nxt;
  logic [15:0] wd_cnt;
  logic [15:0] wd_inc;
  logic        waiting;
  logic        wd_fire;
  logic        timeout_q;
  logic        supported;

  assign supported = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW) ||
                     (opcode == OP_SW) || (opcode == OP_BEQ);

  // Saturating increment so a stuck access never wraps the counter.
  assign wd_inc = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;

  assign state       = cur;
  assign mem_timeout = timeout_q;

  always_comb begin
    nxt          = cur;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    retired      = 1'b0;
    halted       = 1'b0;
    waiting      = 1'b0;
    wd_fire      = 1'b0;

    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          nxt      = S_DECODE;
        end
      end

      S_DECODE: begin
        nxt = S_EXEC;
        if (!supported) begin
`ifdef ILLEGAL_TRAP_EN
          nxt = S_HALT;
`else
          pc_write = 1'b1;
          retired  = 1'b1;
          nxt      = S_FETCH;
`endif
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op = 2'b10;
            nxt    = S_WB;
          end
          OP_I: begin
            alu_src_b = 1'b1;
            alu_op    = 2'b10;
            nxt       = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 1'b1;
            nxt       = S_MEM;
          end
          OP_BEQ: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = alu_zero;
            retired  = 1'b1;
            nxt      = S_FETCH;
          end
          default: begin
            // Opcode changed after DECODE: close the instruction as a NOP so
            // retired/pc_write still occur exactly once.
            pc_write = 1'b1;
            retired  = 1'b1;
            nxt      = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            pc_write = 1'b1;
            retired  = 1'b1;
            nxt      = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LW);
        pc_write  = 1'b1;
        retired   = 1'b1;
        nxt       = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        nxt    = S_HALT;
      end

      default: nxt = S_FETCH;
    endcase

    // A cycle with mem_ready=1 is never a wait cycle, so a completing access
    // always beats a watchdog limit reached in the same cycle.
    waiting = mem_req && !mem_ready;
    wd_fire = (LIMIT != 16'd0) && waiting && (wd_inc >= LIMIT);
    if (wd_fire) nxt = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_FETCH;
      wd_cnt    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      cur <= nxt;
      if ((nxt != cur) && ((nxt == S_FETCH) || (nxt == S_MEM))) begin
        wd_cnt <= 16'd0;
      end else if (waiting) begin
        wd_cnt <= wd_inc;
      end
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl (instantiated with WAIT_LIMIT=4).
//   Each vector is one clock cycle: inputs are driven at the falling edge and
//   the full output word is compared 1 ns later. A fixed table covers the
//   basic instruction classes; hand sequences cover waits, watchdog and reset;
//   randomized instructions are expanded into per-cycle expectations by an
//   instruction-level model (gen).
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       wb_sel;
    logic       retired;
    logic       halted;
    logic       mem_timeout;
  } out_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       zero;
    logic [6:0] op;
    out_t       exp;
    string      tag;
  } vec_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src;
  logic       alu_src_b, reg_write, wb_sel, retired, halted, mem_timeout;
  logic [1:0] alu_op;
  logic [2:0] state;
  out_t       act;

  int n_vec = 0;
  int n_err = 0;
  vec_t vq[$];
  vec_t tbl[19];

  multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_src(mem_addr_src), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .retired(retired),
    .halted(halted), .mem_timeout(mem_timeout), .state(state)
  );

  assign act = {state, mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
                alu_src_b, alu_op, reg_write, wb_sel, retired, halted, mem_timeout};

  // clock
  always #5 clk = ~clk;

  function automatic out_t mk(input logic [2:0] st, input logic req, input logic we,
                              input logic asrc, input logic irw, input logic pcw,
                              input logic pcs, input logic srcb, input logic [1:0] aop,
                              input logic rw, input logic wbs, input logic ret,
                              input logic hlt, input logic tmo);
    return {st, req, we, asrc, irw, pcw, pcs, srcb, aop, rw, wbs, ret, hlt, tmo};
  endfunction

  function automatic out_t blank(input logic [2:0] st);
    out_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic zero,
                      input logic [6:0] op, input out_t e, input string tag);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.zero = zero; v.op = op; v.exp = e; v.tag = tag;
    vq.push_back(v);
  endtask

  // driver: one vector per clock
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n     = !v.rst;
    mem_ready = v.rdy;
    alu_zero  = v.zero;
    opcode    = v.op;
    #1;
    n_vec++;
    if (act !== v.exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %h expected %h", v.tag, n_vec, act, v.exp);
    end
  endtask

  task automatic drain();
    while (vq.size() > 0) apply(vq.pop_front());
  endtask

  // Instruction-level reference: expands one instruction with fw fetch wait
  // cycles and mw memory wait cycles into its per-cycle expected outputs.
  task automatic gen(input logic [6:0] op, input logic zero, input int fw,
                     input int mw, input string tag);
    out_t e;
    bit is_r, is_i, is_lw, is_sw, is_beq;
    is_r = (op == OP_R); is_i = (op == OP_I); is_lw = (op == OP_LW);
    is_sw = (op == OP_SW); is_beq = (op == OP_BEQ);
    for (int k = 0; k < fw; k++) begin
      e = blank(3'd0); e.mem_req = 1'b1;
      push(1'b0, 1'b0, rnd(), op, e, tag);
    end
    e = blank(3'd0); e.mem_req = 1'b1; e.ir_write = 1'b1;
    push(1'b0, 1'b1, rnd(), op, e, tag);
    e = blank(3'd1);
    if (!(is_r || is_i || is_lw || is_sw || is_beq)) begin
`ifdef ILLEGAL_TRAP_EN
      push(1'b0, rnd(), rnd(), op, e, tag);
      e = blank(3'd5); e.halted = 1'b1;
      push(1'b0, rnd(), rnd(), op, e, tag);
      e = blank(3'd0); e.mem_req = 1'b1;
      push(1'b1, 1'b0, rnd(), op, e, tag);
`else
      e.pc_write = 1'b1; e.retired = 1'b1;
      push(1'b0, rnd(), rnd(), op, e, tag);
`endif
      return;
    end
    push(1'b0, rnd(), rnd(), op, e, tag);
    e = blank(3'd2);
    if (is_beq) begin
      e.alu_op = 2'b01; e.pc_write = 1'b1; e.pc_src = zero; e.retired = 1'b1;
      push(1'b0, rnd(), zero, op, e, tag);
      return;
    end
    e.alu_src_b = !is_r;
    e.alu_op = (is_r || is_i) ? 2'b10 : 2'b00;
    push(1'b0, rnd(), rnd(), op, e, tag);
    if (is_lw || is_sw) begin
      e = blank(3'd3); e.mem_req = 1'b1; e.mem_addr_src = 1'b1; e.mem_we = is_sw;
      for (int k = 0; k < mw; k++) push(1'b0, 1'b0, rnd(), op, e, tag);
      if (is_sw) begin
        e.pc_write = 1'b1; e.retired = 1'b1;
        push(1'b0, 1'b1, rnd(), op, e, tag);
        return;
      end
      push(1'b0, 1'b1, rnd(), op, e, tag);
    end
    e = blank(3'd4); e.reg_write = 1'b1; e.wb_sel = is_lw;
    e.pc_write = 1'b1; e.retired = 1'b1;
    push(1'b0, rnd(), rnd(), op, e, tag);
  endtask

  initial begin
    out_t e;
    logic [6:0] op;

    // Fixed table: reset, R-type, beq taken/not taken, sw, I-type (no waits).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, OP_R,   mk(0,1,0,0,0,0,0,0,2'd0,0,0,0,0,0), "reset"};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, OP_R,   mk(0,1,0,0,1,0,0,0,2'd0,0,0,0,0,0), "r_fetch"};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, OP_R,   mk(1,0,0,0,0,0,0,0,2'd0,0,0,0,0,0), "r_decode"};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, OP_R,   mk(2,0,0,0,0,0,0,0,2'd2,0,0,0,0,0), "r_exec"};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, OP_R,   mk(4,0,0,0,0,1,0,0,2'd0,1,0,1,0,0), "r_wb"};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, OP_BEQ, mk(0,1,0,0,1,0,0,0,2'd0,0,0,0,0,0), "beq1_fetch"};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, OP_BEQ, mk(1,0,0,0,0,0,0,0,2'd0,0,0,0,0,0), "beq1_decode"};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, OP_BEQ, mk(2,0,0,0,0,1,1,0,2'd1,0,0,1,0,0), "beq1_exec"};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, OP_BEQ, mk(0,1,0,0,1,0,0,0,2'd0,0,0,0,0,0), "beq0_fetch"};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, OP_BEQ, mk(1,0,0,0,0,0,0,0,2'd0,0,0,0,0,0), "beq0_decode"};
    tbl[10] = '{1'b0, 1'b1, 1'b0, OP_BEQ, mk(2,0,0,0,0,1,0,0,2'd1,0,0,1,0,0), "beq0_exec"};
    tbl[11] = '{1'b0, 1'b1, 1'b0, OP_SW,  mk(0,1,0,0,1,0,0,0,2'd0,0,0,0,0,0), "sw_fetch"};
    tbl[12] = '{1'b0, 1'b0, 1'b0, OP_SW,  mk(1,0,0,0,0,0,0,0,2'd0,0,0,0,0,0), "sw_decode"};
    tbl[13] = '{1'b0, 1'b0, 1'b0, OP_SW,  mk(2,0,0,0,0,0,0,1,2'd0,0,0,0,0,0), "sw_exec"};
    tbl[14] = '{1'b0, 1'b1, 1'b0, OP_SW,  mk(3,1,1,1,0,1,0,0,2'd0,0,0,1,0,0), "sw_mem"};
    tbl[15] = '{1'b0, 1'b1, 1'b0, OP_I,   mk(0,1,0,0,1,0,0,0,2'd0,0,0,0,0,0), "i_fetch"};
    tbl[16] = '{1'b0, 1'b1, 1'b0, OP_I,   mk(1,0,0,0,0,0,0,0,2'd0,0,0,0,0,0), "i_decode"};
    tbl[17] = '{1'b0, 1'b1, 1'b0, OP_I,   mk(2,0,0,0,0,0,0,1,2'd2,0,0,0,0,0), "i_exec"};
    tbl[18] = '{1'b0, 1'b1, 1'b0, OP_I,   mk(4,0,0,0,0,1,0,0,2'd0,1,0,1,0,0), "i_wb"};
    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // lw with two memory wait cycles (7 cycles total).
    gen(OP_LW, 1'b0, 0, 2, "lw_wait2");
    // Three waits on each access: limit would be reached as mem_ready rises.
    gen(OP_LW, 1'b0, 3, 3, "ready_wins");
    gen(OP_SW, 1'b1, 3, 3, "sw_ready_wins");
    // Unsupported opcode.
    gen(7'b1111111, 1'b0, 0, 0, "illegal");
    drain();

    // Watchdog in FETCH: four wait cycles, then HALT until reset.
    for (int k = 0; k < 4; k++) begin
      e = blank(3'd0); e.mem_req = 1'b1;
      push(1'b0, 1'b0, rnd(), OP_R, e, "wd_fetch_wait");
    end
    for (int k = 0; k < 3; k++) begin
      e = blank(3'd5); e.halted = 1'b1; e.mem_timeout = 1'b1;
      push(1'b0, rnd(), rnd(), OP_R, e, "wd_fetch_halt");
    end
    e = blank(3'd0); e.mem_req = 1'b1;
    push(1'b1, 1'b0, 1'b0, OP_R, e, "wd_reset");
    gen(OP_R, 1'b0, 1, 0, "after_wd");

    // Watchdog in MEM for lw.
    e = blank(3'd0); e.mem_req = 1'b1; e.ir_write = 1'b1;
    push(1'b0, 1'b1, 1'b0, OP_LW, e, "wdm_fetch");
    push(1'b0, 1'b0, 1'b0, OP_LW, blank(3'd1), "wdm_decode");
    e = blank(3'd2); e.alu_src_b = 1'b1;
    push(1'b0, 1'b0, 1'b0, OP_LW, e, "wdm_exec");
    for (int k = 0; k < 4; k++) begin
      e = blank(3'd3); e.mem_req = 1'b1; e.mem_addr_src = 1'b1;
      push(1'b0, 1'b0, rnd(), OP_LW, e, "wdm_wait");
    end
    e = blank(3'd5); e.halted = 1'b1; e.mem_timeout = 1'b1;
    push(1'b0, 1'b1, 1'b0, OP_LW, e, "wdm_halt");
    e = blank(3'd0); e.mem_req = 1'b1;
    push(1'b1, 1'b0, 1'b0, OP_LW, e, "wdm_reset");

    // Reset pulsed in the middle of an sw memory wait: no retire, no PC write.
    e = blank(3'd0); e.mem_req = 1'b1; e.ir_write = 1'b1;
    push(1'b0, 1'b1, 1'b0, OP_SW, e, "rst_sw_fetch");
    push(1'b0, 1'b1, 1'b0, OP_SW, blank(3'd1), "rst_sw_decode");
    e = blank(3'd2); e.alu_src_b = 1'b1;
    push(1'b0, 1'b0, 1'b0, OP_SW, e, "rst_sw_exec");
    e = blank(3'd3); e.mem_req = 1'b1; e.mem_addr_src = 1'b1; e.mem_we = 1'b1;
    push(1'b0, 1'b0, 1'b0, OP_SW, e, "rst_sw_mem");
    push(1'b0, 1'b0, 1'b0, OP_SW, e, "rst_sw_mem");
    e = blank(3'd0); e.mem_req = 1'b1;
    push(1'b1, 1'b0, 1'b0, OP_SW, e, "rst_sw_abort");
    push(1'b0, 1'b0, 1'b0, OP_SW, e, "rst_sw_refetch");
    e.ir_write = 1'b1;
    push(1'b0, 1'b1, 1'b0, OP_SW, e, "rst_sw_refetch");
    push(1'b0, 1'b0, 1'b0, OP_SW, blank(3'd1), "rst_sw_decode2");
    e = blank(3'd2); e.alu_src_b = 1'b1;
    push(1'b0, 1'b0, 1'b0, OP_SW, e, "rst_sw_exec2");
    e = blank(3'd3); e.mem_req = 1'b1; e.mem_addr_src = 1'b1; e.mem_we = 1'b1;
    e.pc_write = 1'b1; e.retired = 1'b1;
    push(1'b0, 1'b1, 1'b0, OP_SW, e, "rst_sw_mem2");
    drain();

    // Randomized instruction stream; waits stay below the watchdog limit.
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        default: op = 7'($urandom_range(0, 127));
      endcase
      gen(op, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), "random");
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the single-issue RV32I teaching core. It sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB. It drives the shared datapath: PC register, IR, immediate generator/ALU operand mux, register file and the single unified memory port. Memory accesses use a req/ready handshake, and an optional watchdog bounds each access.

## Interface
- WAIT_LIMIT, default 0: maximum cycles `mem_req` may stay high without `mem_ready`. 0 disables the watchdog. Counter width is 16 bits, so legal values are 0–65535.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- alu_zero  in  1  ALU zero flag, valid combinationally in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by `mem_req`
- mem_addr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC this cycle
- pc_src  out  1  0 = PC+4, 1 = PC+imm
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 sub, 10 decode funct3/funct7
- reg_write  out  1  register-file write enable
- wb_sel  out  1  0 = ALU result, 1 = memory data register
- retired  out  1  one-cycle pulse when an instruction completes
- halted  out  1  controller is stopped in HALT
- mem_timeout  out  1  sticky; the watchdog fired
- state  out  3  current state, for debug

## Operation
- States and encodings:
  - FETCH = 0
  - DECODE = 1
  - EXEC = 2
  - MEM = 3
  - WB = 4
  - HALT = 5
- Any other encoding goes to FETCH on the next clock.
- FETCH:
  - Outputs: `mem_req`=1, `mem_addr_src`=0, `mem_we`=0.
  - When `mem_ready`=1: `ir_write`=1 in that cycle, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: all enables 0; next state EXEC. Unsupported opcode: see Configuration.
- EXEC, by opcode:
  - 0110011 (R-type): `alu_src_b`=0, `alu_op`=10, next WB.
  - 0010011 (I-type ALU): `alu_src_b`=1, `alu_op`=10, next WB.
  - 0000011 (lw) and 0100011 (sw): `alu_src_b`=1, `alu_op`=00, next MEM.
  - 1100011 (beq): `alu_src_b`=0, `alu_op`=01, `pc_write`=1, `pc_src`=`alu_zero`, `retired`=1, next FETCH.
- MEM:
  - Outputs: `mem_req`=1, `mem_addr_src`=1, `mem_we`=1 for sw, 0 for lw.
  - Without `mem_ready`: hold state.
  - With `mem_ready`, sw: `pc_write`=1, `pc_src`=0, `retired`=1, next FETCH.
  - With `mem_ready`, lw: next WB.
- WB:
  - Outputs: `reg_write`=1, `wb_sel`=1 for lw, 0 otherwise; `pc_write`=1, `pc_src`=0, `retired`=1.
  - Next state FETCH.
- Output timing:
  - Outputs not listed for a state are 0.
  - Outputs are combinational from the registered state, `opcode`, `mem_ready` and `alu_zero`.
  - Every unlisted output holds its value throughout a wait cycle.
- Watchdog:
  - A 16-bit counter clears on entry to FETCH or MEM and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT while still waiting, then next state is HALT and `mem_timeout` is set.
  - The counter saturates at 16'hFFFF.
- HALT: all control outputs 0, `halted`=1, `state`=5. Only reset exits HALT.
- `mem_ready` while `mem_req`=0 is ignored.

## Timing
- Reset:
  - The async assert forces `state`=FETCH and the watchdog counter to 0.
  - `mem_timeout`=0, `halted`=0.
  - Combinational outputs take their FETCH values: `mem_req`=1, everything else 0.
- Reset may assert in any state and aborts the instruction with no PC or register update.
- The first access is requested in the first cycle after deassert.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - beq: 3 cycles.
  - R-type, I-type and sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle adds 1 cycle.
- `retired` and `pc_write` coincide, exactly once per instruction.
- A timeout reached in the same cycle that `mem_ready` rises: `mem_ready` wins and the access completes normally.

## Configuration
- Macro: `ILLEGAL_TRAP_EN`.
- Defined:
  - An opcode outside the five supported ones in DECODE leads to HALT next, with `halted`=1 and `retired`=0.
  - `mem_timeout` stays 0 in this case.
- Undefined:
  - An unsupported opcode in DECODE is treated as a NOP.
  - DECODE drives `pc_write`=1, `pc_src`=0, `retired`=1, and the next state is FETCH (2 cycles total).

## Test plan
- R-type with `mem_ready`=1: states 0→1→2→4→0; `reg_write`=1 and `wb_sel`=0 in WB; `retired` pulses once at cycle 4.
- lw with `mem_ready` low for 2 MEM cycles: `mem_req`=1, `mem_addr_src`=1, `mem_we`=0 for 3 cycles; then WB with `wb_sel`=1; total 7 cycles.
- beq with `alu_zero`=1, then again with `alu_zero`=0: `pc_write`=1 in EXEC with `pc_src`=1 and `pc_src`=0 respectively; 3 cycles each.
- WAIT_LIMIT=4 with `mem_ready` held 0 in FETCH: HALT after 4 wait cycles; `mem_timeout`=1, `halted`=1; stays there until `rst_n`=0.
- sw, `rst_n` pulsed low mid-MEM: immediate `state`=0 with `mem_req`=1; no `retired` pulse and no `pc_write` pulse seen.
- opcode 7'b1111111: with `ILLEGAL_TRAP_EN`, HALT after DECODE; without it, `retired` pulses in DECODE and the controller returns to FETCH.
